bcd_operand_loader: RTL and testbench

- Upstream stage of the 2-digit BCD adder/display datapath.
- Captures two 2-digit BCD operands (A1:A0, then B1:B0) from the 8 slide switches, one operand per debounced pushbutton press.
- Rejects non-BCD digits and holds the captured digits stable for the adder.
- Raises `valid` once both operands are loaded.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_operand_loader_if.sv | 27 ++
 rtl/key_debounce.sv | 50 +++++
 rtl/bcd_operand_loader.sv | 98 +++++++++
 tb/tb_bcd_operand_loader.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the 2-digit BCD datapath: digit limits, loader
// state encoding and the BCD digit check used by loader, adder and display.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_FULL = 2'b10
  } state_t;

  // One 2-digit BCD operand, laid out exactly like the slide switches.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

  function automatic logic is_bcd2(input bcd2_t value);
    return is_bcd(value.tens) && is_bcd(value.units);
  endfunction

endpackage

// File: rtl/bcd_operand_loader_if.sv
// Board-side signal bundle of the operand loader: switches and load key in,
// captured digits and status out.
interface bcd_operand_loader_if;

  logic [7:0] SW;
  logic       KEY_LOAD;
  logic [3:0] A1;
  logic [3:0] A0;
  logic [3:0] B1;
  logic [3:0] B0;
  logic       valid;
  logic       err;
  logic [1:0] state;

  // Board / stimulus side.
  modport master (
    output SW, KEY_LOAD,
    input  A1, A0, B1, B0, valid, err, state
  );

  // Loader side.
  modport slave (
    input  SW, KEY_LOAD,
    output A1, A0, B1, B0, valid, err, state
  );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low pushbutton and emits a single
// one-cycle press pulse for every accepted 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // The key is released (high) out of reset so no spurious press appears.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, which is what turns sync1/sync2 into a real two-stage chain.
      sync1 <= key_n;
      sync2 <= sync1;

      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      stable_d <= stable;
      press    <= stable_d & ~stable;
    end
  end

endmodule

// File: rtl/bcd_operand_loader.sv
// Loads operand A then operand B from the switches, one per debounced key
// press, rejecting non-BCD digits; valid marks a complete operand pair.
module bcd_operand_loader
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  bcd_operand_loader_if.slave  bus
);

  logic   press;
  bcd2_t  sw;
  bcd2_t  op_a;
  bcd2_t  op_b;
  state_t state_q;
  logic   valid_q;
  logic   err_q;
  logic   sw_ok;

  assign sw    = bus.SW;
  assign sw_ok = is_bcd2(sw);

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (bus.KEY_LOAD),
    .press    (press)
  );

  // A rejected press only raises err; everything else holds its value.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_A;
      op_a    <= '0;
      op_b    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (press) begin
            if (sw_ok) begin
              op_a    <= sw;
              err_q   <= 1'b0;
              state_q <= S_B;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_B: begin
          if (press) begin
            if (sw_ok) begin
              op_b    <= sw;
              err_q   <= 1'b0;
              valid_q <= 1'b1;
              state_q <= S_FULL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_FULL: begin
          // A fresh press starts a new operation: A reloads, B clears.
          if (press) begin
            if (sw_ok) begin
              op_a    <= sw;
              op_b    <= '0;
              valid_q <= 1'b0;
              err_q   <= 1'b0;
              state_q <= S_B;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_A;
        end
      endcase
    end
  end

  assign bus.A1    = op_a.tens;
  assign bus.A0    = op_a.units;
  assign bus.B1    = op_b.tens;
  assign bus.B0    = op_b.units;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Bench for bcd_operand_loader: directed test-plan sequences plus random key
// activity, every cycle compared against an arithmetic model of the loader.
module tb_bcd_operand_loader;

  localparam int DC = 4;

  logic clk;
  logic reset;

  bcd_operand_loader_if bus ();

  bcd_operand_loader #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (16)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: key seen two edges late, accepted after DC consecutive
  // differing samples, load two edges after a fall; operands kept as 0..99.
  bit m_k1, m_k2, m_stable, m_fell, m_press, m_err;
  int m_run, m_phase, m_a, m_b;

  always @(posedge clk) begin
    if (reset) begin
      m_k1 = 1; m_k2 = 1; m_stable = 1; m_run = 0;
      m_fell = 0; m_press = 0;
      m_phase = 0; m_a = 0; m_b = 0; m_err = 0;
    end else begin
      if (m_press) begin
        int t, u;
        t = int'(bus.SW) / 16;
        u = int'(bus.SW) % 16;
        if (t > 9 || u > 9) begin
          m_err = 1;
        end else begin
          m_err = 0;
          if (m_phase == 0) begin
            m_a = t * 10 + u; m_phase = 1;
          end else if (m_phase == 1) begin
            m_b = t * 10 + u; m_phase = 2;
          end else begin
            m_a = t * 10 + u; m_b = 0; m_phase = 1;
          end
        end
      end
      m_press = m_fell;
      m_fell  = 0;
      if (m_k2 != m_stable) begin
        m_run++;
        if (m_run == DC) begin
          m_stable = m_k2;
          m_run    = 0;
          if (!m_stable) m_fell = 1;
        end
      end else begin
        m_run = 0;
      end
      m_k2 = m_k1;
      m_k1 = bus.KEY_LOAD;
    end
  end

  function automatic logic [19:0] model_vec();
    return {4'(m_a / 10), 4'(m_a % 10), 4'(m_b / 10), 4'(m_b % 10),
            (m_phase == 2), m_err, 2'(m_phase)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.A1, bus.A0, bus.B1, bus.B0, bus.valid, bus.err, bus.state};
  endfunction

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_outputs", 32'(dut_vec()), 32'(model_vec()));
      check("press_pulse", 32'(dut.u_deb.press), 32'(m_press));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outs(input string name, input logic [3:0] a1, input logic [3:0] a0,
                            input logic [3:0] b1, input logic [3:0] b0,
                            input logic v, input logic e, input logic [1:0] st);
    check(name, 32'(dut_vec()), 32'({a1, a0, b1, b0, v, e, st}));
  endtask

  task automatic press_key(input logic [7:0] sw);
    bus.SW = sw;
    bus.KEY_LOAD = 1'b0;
    wait_cycles(12);
    bus.KEY_LOAD = 1'b1;
    wait_cycles(10);
  endtask

  task automatic low_pulse(input int low, input int high);
    bus.KEY_LOAD = 1'b0;
    wait_cycles(low);
    bus.KEY_LOAD = 1'b1;
    wait_cycles(high);
  endtask

  initial begin
    reset = 1'b1;
    bus.KEY_LOAD = 1'b1;
    bus.SW = 8'h00;
    wait_cycles(3);
    reset = 1'b0;
    cmp_en = 1;
    wait_cycles(1);
    check_outs("reset_state", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);
    check("reset_no_press", 32'(dut.u_deb.press), 32'd0);

    // Exact latency: outputs change on the 8th edge after KEY_LOAD falls.
    bus.SW = 8'h47;
    bus.KEY_LOAD = 1'b0;
    wait_cycles(7);
    check_outs("latency_edge7", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);
    wait_cycles(1);
    check_outs("latency_edge8", 4'd4, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01);
    wait_cycles(4);
    bus.KEY_LOAD = 1'b1;
    wait_cycles(10);

    press_key(8'h95);
    check_outs("load_b_95", 4'd4, 4'd7, 4'd9, 4'd5, 1'b1, 1'b0, 2'b10);

    press_key(8'h08);
    check_outs("full_restart", 4'd0, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01);

    press_key(8'h3C);
    check_outs("reject_3c", 4'd0, 4'd8, 4'd0, 4'd0, 1'b0, 1'b1, 2'b01);

    press_key(8'h12);
    check_outs("load_b_12", 4'd0, 4'd8, 4'd1, 4'd2, 1'b1, 1'b0, 2'b10);

    // Glitches shorter than the debounce window never load.
    bus.SW = 8'h55;
    low_pulse(1, 2);
    low_pulse(2, 2);
    low_pulse(3, 10);
    check_outs("glitches_ignored", 4'd0, 4'd8, 4'd1, 4'd2, 1'b1, 1'b0, 2'b10);

    // A long hold gives exactly one load (a second would reach S_FULL).
    bus.SW = 8'h25;
    bus.KEY_LOAD = 1'b0;
    wait_cycles(200);
    bus.KEY_LOAD = 1'b1;
    wait_cycles(10);
    check_outs("long_hold_once", 4'd2, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01);

    // Reset in the middle of a debounce count discards the press.
    bus.SW = 8'h66;
    bus.KEY_LOAD = 1'b0;
    wait_cycles(4);
    reset = 1'b1;
    bus.KEY_LOAD = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(20);
    check_outs("reset_mid_debounce", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);

    press_key(8'h31);
    check_outs("load_after_reset", 4'd3, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01);

    // Random key activity, switch values and occasional resets.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) bus.SW = 8'($urandom);
      else bus.SW = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        wait_cycles($urandom_range(1, 3));
        reset = 1'b0;
      end
      bus.KEY_LOAD = 1'b0;
      for (int k = $urandom_range(1, 12); k > 0; k--) begin
        if ($urandom_range(0, 5) == 0) bus.SW = 8'($urandom);
        wait_cycles(1);
      end
      bus.KEY_LOAD = 1'b1;
      wait_cycles($urandom_range(2, 12));
    end
    wait_cycles(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
